// File: rtl/packet_rx.sv
`timescale 1ns/1ps
// packet_rx: frames a byte-serial packet stream onto the packet FIFO write port.
// Define RX_CRC_CHECK_EN to compare the crc byte against the XOR of header and data bytes.
module packet_rx #(
    parameter int WIDTH     = 11,
    parameter int UWIDTH    = 8,
    parameter int PTR_IN_SZ = 4
) (
    input  logic                 clk1,
    input  logic                 rst,
    input  logic [UWIDTH-1:0]    in_data,
    input  logic                 in_valid,
    input  logic                 in_last,
    output logic                 in_ready,
    input  logic                 wfull,
    output logic [PTR_IN_SZ-1:0] waddr_in,
    output logic [UWIDTH-1:0]    wdata,
    output logic                 winc,
    output logic                 err,
    output logic [1:0]           err_code
);
    localparam logic [UWIDTH-1:0] MAX_SIZE = UWIDTH'(WIDTH - 4);

    typedef enum logic [2:0] {
        IDLE, HDR_DST, HDR_SIZE, DATA, CRC, COMMIT, DROP
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'b00,
        ERR_SIZE  = 2'b01,
        ERR_FRAME = 2'b10,
        ERR_CRC   = 2'b11
    } err_t;

    state_t               state, next_state;
    err_t                 code_next;
    logic                 err_next, commit, ready_q;
    logic                 accept, write_byte, size_bad;
    logic [PTR_IN_SZ-1:0] idx, remaining;

    // wfull only gates the start of a packet; a frame already underway is never stalled.
    assign in_ready   = ready_q & ~((state == IDLE) & wfull);
    assign accept     = in_valid & in_ready;
    assign write_byte = accept & (state != DROP);
    assign size_bad   = (in_data == '0) || (in_data > MAX_SIZE);

`ifdef RX_CRC_CHECK_EN
    logic [UWIDTH-1:0] chk_val;

    always_ff @(posedge clk1) begin
        if (rst) begin
            chk_val <= '0;
        end else if (accept) begin
            if (state == IDLE)
                chk_val <= in_data;
            else if (state == HDR_DST || state == HDR_SIZE || state == DATA)
                chk_val <= chk_val ^ in_data;
        end
    end
`endif

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        next_state = state;
        err_next   = 1'b0;
        code_next  = ERR_NONE;
        commit     = 1'b0;
        if (state == COMMIT) begin
            next_state = IDLE;
        end else if (accept) begin
            unique case (state)
                IDLE: begin
                    if (in_last) begin
                        err_next  = 1'b1;
                        code_next = ERR_FRAME;
                    end else begin
                        next_state = HDR_DST;
                    end
                end
                HDR_DST: begin
                    if (in_last) begin
                        err_next   = 1'b1;
                        code_next  = ERR_FRAME;
                        next_state = IDLE;
                    end else begin
                        next_state = HDR_SIZE;
                    end
                end
                HDR_SIZE: begin
                    if (size_bad) begin
                        err_next   = 1'b1;
                        code_next  = ERR_SIZE;
                        next_state = in_last ? IDLE : DROP;
                    end else if (in_last) begin
                        err_next   = 1'b1;
                        code_next  = ERR_FRAME;
                        next_state = IDLE;
                    end else begin
                        next_state = DATA;
                    end
                end
                DATA: begin
                    if (in_last) begin
                        err_next   = 1'b1;
                        code_next  = ERR_FRAME;
                        next_state = IDLE;
                    end else if (remaining == PTR_IN_SZ'(1)) begin
                        next_state = CRC;
                    end
                end
                CRC: begin
                    if (!in_last) begin
                        err_next   = 1'b1;
                        code_next  = ERR_FRAME;
                        next_state = DROP;
                    end
`ifdef RX_CRC_CHECK_EN
                    else if (in_data != chk_val) begin
                        err_next   = 1'b1;
                        code_next  = ERR_CRC;
                        next_state = IDLE;
                    end
`endif
                    else begin
                        commit     = 1'b1;
                        next_state = COMMIT;
                    end
                end
                DROP: begin
                    if (in_last) next_state = IDLE;
                end
                default: next_state = IDLE;
            endcase
        end
    end

    // NOTE: reset is synchronous; sequential state uses non-blocking assignments only.
    always_ff @(posedge clk1) begin
        if (rst) begin
            state     <= IDLE;
            ready_q   <= 1'b0;
            idx       <= '0;
            remaining <= '0;
            waddr_in  <= '0;
            wdata     <= '0;
            winc      <= 1'b0;
            err       <= 1'b0;
            err_code  <= ERR_NONE;
        end else begin
            state   <= next_state;
            ready_q <= (next_state != COMMIT);
            winc    <= commit;
            err     <= err_next;
            if (err_next) err_code <= code_next;
            if (write_byte) begin
                waddr_in <= idx;
                wdata    <= in_data;
            end
            if (next_state == IDLE)
                idx <= '0;
            else if (write_byte)
                idx <= idx + PTR_IN_SZ'(1);
            if (accept && state == HDR_SIZE)
                remaining <= in_data[PTR_IN_SZ-1:0];
            else if (accept && state == DATA)
                remaining <= remaining - PTR_IN_SZ'(1);
        end
    end

endmodule

// File: tb/tb_packet_rx.sv
`timescale 1ns/1ps
// Bench for packet_rx: directed cases with literal expectations, then randomized frames
// compared every cycle against a byte-position reference model.
module tb_packet_rx;
    typedef logic [7:0] byte_q_t[$];

    localparam int MAX_SIZE = 7;
`ifdef RX_CRC_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic       clk1 = 1'b0;
    logic       rst, in_valid, in_last, wfull;
    logic [7:0] in_data;
    logic       in_ready, winc, err;
    logic [3:0] waddr_in;
    logic [7:0] wdata;
    logic [1:0] err_code;

    packet_rx dut (
        .clk1     (clk1),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_last  (in_last),
        .in_ready (in_ready),
        .wfull    (wfull),
        .waddr_in (waddr_in),
        .wdata    (wdata),
        .winc     (winc),
        .err      (err),
        .err_code (err_code)
    );

    always #5 clk1 = ~clk1;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    bit rand_full = 1'b0;
    bit bubbles   = 1'b0;

    // Reference model: position of the next byte within the packet, plus drop/commit-gap flags.
    int         pos = 0;
    int         size = 0;
    bit         dropping = 1'b0, gap = 1'b0, ready_ok = 1'b0;
    logic [7:0] chk = '0;
    logic [3:0] e_waddr = '0;
    logic [7:0] e_wdata = '0;
    bit         e_winc = 1'b0, e_err = 1'b0;
    logic [1:0] e_code = 2'b00;

    // Observations used by the directed literal checks.
    int         winc_cnt = 0, err_cnt = 0, crc_cyc = 0, src_cyc = 0;
    logic [3:0] last_winc_addr = '0;
    logic [7:0] last_winc_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic bit model_ready(input logic full);
        return ready_ok && !gap && (pos > 0 || dropping || !full);
    endfunction

    function automatic bit crc_good(input logic [7:0] d);
        return !CHECK_EN || (d == chk);
    endfunction

    task automatic flag_err(input logic [1:0] c);
        e_err  = 1'b1;
        e_code = c;
    endtask

    always @(posedge clk1) begin
        bit acc, crc_byte;
        cyc++;
        if (rst) begin
            pos = 0; size = 0; dropping = 1'b0; gap = 1'b0; ready_ok = 1'b0;
            e_waddr = '0; e_wdata = '0; e_winc = 1'b0; e_err = 1'b0; e_code = 2'b00;
        end else begin
            acc      = in_valid && model_ready(wfull);
            e_winc   = 1'b0;
            e_err    = 1'b0;
            gap      = 1'b0;
            ready_ok = 1'b1;
            if (acc && dropping) begin
                if (in_last) dropping = 1'b0;
            end else if (acc) begin
                e_waddr = 4'(pos);
                e_wdata = in_data;
                if (pos == 0) begin
                    chk     = '0;
                    src_cyc = cyc;
                end
                if (pos == 2) size = int'(in_data);
                crc_byte = (pos >= 3) && (pos == size + 3);
                if (!crc_byte) chk ^= in_data;
                if (pos == 2 && (size == 0 || size > MAX_SIZE)) begin
                    flag_err(2'b01);
                    pos      = 0;
                    dropping = !in_last;
                end else if (crc_byte) begin
                    pos = 0;
                    if (!in_last) begin
                        flag_err(2'b10);
                        dropping = 1'b1;
                    end else if (!crc_good(in_data)) begin
                        flag_err(2'b11);
                    end else begin
                        e_winc  = 1'b1;
                        gap     = 1'b1;
                        crc_cyc = cyc;
                    end
                end else if (in_last) begin
                    flag_err(2'b10);
                    pos = 0;
                end else begin
                    pos++;
                end
            end
        end
        #2;
        if (winc === 1'b1) begin
            winc_cnt++;
            last_winc_addr = waddr_in;
            last_winc_data = wdata;
        end
        if (err === 1'b1) err_cnt++;
        check("in_ready", in_ready, model_ready(wfull));
        check("waddr_in", waddr_in, e_waddr);
        check("wdata", wdata, e_wdata);
        check("winc", winc, e_winc);
        check("err", err, e_err);
        check("err_code", err_code, e_code);
    end

    // NOTE: inputs change only on the falling edge, with blocking assignments.
    task automatic tick();
        @(negedge clk1);
        if (rand_full) wfull = ($urandom_range(0, 3) == 0);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l);
        int   waited = 0;
        logic rdy;
        if (bubbles && $urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            tick();
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        forever begin
            #1 rdy = in_ready;
            @(posedge clk1);
            tick();
            if (rdy) break;
            waited++;
            if (waited > 60) begin
                n_checks++;
                $display("FAIL accept_wait: byte %0d not accepted within 60 cycles", d);
                break;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_pkt(input byte_q_t q);
        foreach (q[i]) send_byte(q[i], i == q.size() - 1);
    endtask

    task automatic random_frame();
        byte_q_t    q;
        int         kind = $urandom_range(0, 9);
        int         sz = $urandom_range(1, MAX_SIZE);
        int         k;
        logic [7:0] x;
        q.push_back(8'($urandom));
        q.push_back(8'($urandom));
        if (kind == 0) begin
            q.push_back($urandom_range(0, 1) ? 8'd0 : 8'($urandom_range(8, 255)));
            repeat ($urandom_range(0, 3)) q.push_back(8'($urandom));
        end else begin
            q.push_back(8'(sz));
            repeat (sz) q.push_back(8'($urandom));
            x = '0;
            foreach (q[i]) x ^= q[i];
            q.push_back((kind == 1) ? 8'($urandom) : x);
            if (kind == 2) begin
                k = $urandom_range(0, q.size() - 2);
                q = q[0:k];
            end
            if (kind == 3) repeat ($urandom_range(1, 3)) q.push_back(8'($urandom));
        end
        send_pkt(q);
        idle($urandom_range(0, 2));
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        byte_q_t p;
        int      w0, e0, c1;
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; wfull = 1'b0;
        repeat (3) tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_waddr", waddr_in, 0);
        check("rst_wdata", wdata, 0);
        check("rst_winc", winc, 0);
        check("rst_err_code", err_code, 0);
        rst = 1'b0;
        tick();

        // Reset after the size byte abandons the packet.
        send_byte(8'd10, 1'b0);
        send_byte(8'd160, 1'b0);
        send_byte(8'd3, 1'b0);
        rst = 1'b1;
        w0  = winc_cnt;
        tick();
        check("midrst_waddr", waddr_in, 0);
        check("midrst_wdata", wdata, 0);
        check("midrst_ready", in_ready, 0);
        rst = 1'b0;
        tick();
        check("midrst_no_winc", winc_cnt - w0, 0);

        // Good packet: 10^160^3^0^1^2 = 170.
        w0 = winc_cnt; e0 = err_cnt;
        p = '{8'd10, 8'd160, 8'd3, 8'd0, 8'd1, 8'd2, 8'd170};
        send_pkt(p);
        idle(2);
        check("good_winc_cnt", winc_cnt - w0, 1);
        check("good_winc_addr", last_winc_addr, 6);
        check("good_winc_data", last_winc_data, 170);
        check("good_no_err", err_cnt - e0, 0);

        // Same packet with a bad crc byte.
        w0 = winc_cnt;
        p = '{8'd10, 8'd160, 8'd3, 8'd0, 8'd1, 8'd2, 8'd15};
        send_pkt(p);
        idle(2);
`ifdef RX_CRC_CHECK_EN
        check("badcrc_no_winc", winc_cnt - w0, 0);
        check("badcrc_code", err_code, 3);
`else
        check("badcrc_winc_cnt", winc_cnt - w0, 1);
        check("badcrc_wdata", last_winc_data, 15);
`endif

        // Size 8 is dropped until in_last; then a max-size packet fills index 10.
        w0 = winc_cnt; e0 = err_cnt;
        p = '{8'd1, 8'd2, 8'd8, 8'd5, 8'd6, 8'd7};
        send_pkt(p);
        idle(1);
        check("size_code", err_code, 1);
        check("size_err_cnt", err_cnt - e0, 1);
        check("size_no_winc", winc_cnt - w0, 0);
        p = '{8'd1, 8'd2, 8'd7, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd4};
        send_pkt(p);
        idle(2);
        check("max_winc_cnt", winc_cnt - w0, 1);
        check("max_winc_addr", last_winc_addr, 10);
        check("max_winc_data", last_winc_data, 4);

        // in_last on the second data byte of a size-4 packet.
        w0 = winc_cnt;
        p = '{8'd3, 8'd4, 8'd4, 8'd9, 8'd9};
        send_pkt(p);
        idle(1);
        check("frame_code", err_code, 2);
        check("frame_no_winc", winc_cnt - w0, 0);

        // Backpressure: wfull in IDLE blocks the start of a packet.
        wfull = 1'b1; in_valid = 1'b1; in_data = 8'd55; in_last = 1'b0;
        repeat (3) begin
            tick();
            #1 check("bp_in_ready", in_ready, 0);
        end
        check("bp_hold_waddr", waddr_in, 4);
        check("bp_hold_wdata", wdata, 9);
        wfull = 1'b0;
        w0 = winc_cnt;
        p = '{8'd55, 8'd1, 8'd1, 8'd9, 8'd62};
        send_pkt(p);
        idle(2);
        check("bp_winc_cnt", winc_cnt - w0, 1);
        check("bp_winc_data", last_winc_data, 62);

        // Back-to-back packets: next source_id accepted two edges after the crc byte.
        w0 = winc_cnt;
        p = '{8'd1, 8'd2, 8'd1, 8'd3, 8'd1};
        send_pkt(p);
        c1 = crc_cyc;
        p = '{8'd4, 8'd5, 8'd2, 8'd6, 8'd7, 8'd2};
        send_pkt(p);
        idle(2);
        check("b2b_spacing", src_cyc - c1, 2);
        check("b2b_winc_cnt", winc_cnt - w0, 2);

        rand_full = 1'b1;
        bubbles   = 1'b1;
        repeat (300) random_frame();
        rand_full = 1'b0;
        wfull     = 1'b0;
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
